// File: rtl/gray_to_binary_decoder_if.sv
// Stream interface for the gray-to-binary decoder.
//   in_valid/in_ready/in_gray : gray word input stream
//   out_valid/out_ready       : decoded word output stream
//   out_bin                   : binary value of the accepted gray word
//   out_dir/out_wrap          : step direction (+1) and boundary crossing
//   out_step_err/err_count    : step-violation flag and saturating count
// Modports: slave = decoder side, master = producer/consumer side.
interface gray_to_binary_decoder_if #(
   parameter int WIDTH     = 3,
   parameter int ERR_CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_gray;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_bin;
   logic                 out_dir;
   logic                 out_wrap;
   logic                 out_step_err;
   logic [ERR_CNT_W-1:0] err_count;

   modport slave (
      input  in_valid, in_gray, out_ready,
      output in_ready, out_valid, out_bin, out_dir, out_wrap, out_step_err, err_count
   );

   modport master (
      output in_valid, in_gray, out_ready,
      input  in_ready, out_valid, out_bin, out_dir, out_wrap, out_step_err, err_count
   );
endinterface

// File: rtl/gray_to_binary_decoder.sv
// Registered gray-to-binary decoder with valid/ready streams on both sides.
// Tracks consecutive accepted words to report step direction and wrap.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gray_to_binary_decoder_if.slave (input stream, decoded output,
//           out_dir, out_wrap, out_step_err, err_count)
// Build option: define GRAY_STEP_CHECK_EN to compile in the single-bit-step
// checker (prev_gray history, out_step_err, saturating err_count). Without it
// out_step_err and err_count are constant zero.
module gray_to_binary_decoder #(
   parameter int WIDTH     = 3,
   parameter int ERR_CNT_W = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   gray_to_binary_decoder_if.slave bus
);

   logic [WIDTH-1:0] dec;
   logic [WIDTH-1:0] prev_bin;
   logic [WIDTH-1:0] prev_inc;
   logic             has_prev;
   logic             accept;
   logic             dir_next;
   logic             wrap_next;

   // bin[i] is the XOR of all gray bits from i up to the MSB
   always_comb begin
      dec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dec[i] = ^(bus.in_gray >> i);
      end
   end

   // Single output register: a drain and a new accept can share a cycle
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   assign prev_inc  = prev_bin + 1'b1;
   assign dir_next  = has_prev && (dec == prev_inc);
   // Downward wrap is a -1 step from 0 to all-ones; any other step size
   // leaves both dir and wrap low.
   assign wrap_next = has_prev &&
                      ((dir_next && (prev_bin == {WIDTH{1'b1}})) ||
                       (!dir_next && (dec == {WIDTH{1'b1}}) && (prev_bin == '0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_bin   <= '0;
         bus.out_dir   <= 1'b0;
         bus.out_wrap  <= 1'b0;
         prev_bin      <= '0;
         has_prev      <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_bin   <= dec;
         bus.out_dir   <= dir_next;
         bus.out_wrap  <= wrap_next;
         prev_bin      <= dec;
         has_prev      <= 1'b1;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0]     prev_gray;
   logic                 step_err_next;
   logic                 step_err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // A repeated word (zero changed bits) is an error as well
   assign step_err_next = has_prev && ($countones(bus.in_gray ^ prev_gray) != 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_gray  <= '0;
         step_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else if (accept) begin
         prev_gray  <= bus.in_gray;
         step_err_q <= step_err_next;
         if (step_err_next && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign bus.out_step_err = step_err_q;
   assign bus.err_count    = err_cnt_q;
`else
   assign bus.out_step_err = 1'b0;
   assign bus.err_count    = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Directed bench for gray_to_binary_decoder (WIDTH=3, ERR_CNT_W=8).
// Table-driven walks plus hand-written backpressure, step-error and
// mid-stream reset sequences. Expectations follow GRAY_STEP_CHECK_EN.
module tb_gray_to_binary_decoder;

   localparam int W  = 3;
   localparam int EW = 8;

   typedef struct {
      logic [W-1:0] gray;
      logic [W-1:0] bin;
      logic         dir;
      logic         wrap;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   passes;

   gray_to_binary_decoder_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

   gray_to_binary_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef GRAY_STEP_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // advance one active edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_gray  = '0;
      bus.out_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   vec_t vecs[12];
   logic [EW-1:0] exp_cnt;

   initial begin
      checks = 0;
      passes = 0;
      // upward walk 0..7,0 then continuing downward 7,6,5
      vecs[0]  = '{3'b000, 3'd0, 1'b0, 1'b0};
      vecs[1]  = '{3'b001, 3'd1, 1'b1, 1'b0};
      vecs[2]  = '{3'b011, 3'd2, 1'b1, 1'b0};
      vecs[3]  = '{3'b010, 3'd3, 1'b1, 1'b0};
      vecs[4]  = '{3'b110, 3'd4, 1'b1, 1'b0};
      vecs[5]  = '{3'b111, 3'd5, 1'b1, 1'b0};
      vecs[6]  = '{3'b101, 3'd6, 1'b1, 1'b0};
      vecs[7]  = '{3'b100, 3'd7, 1'b1, 1'b0};
      vecs[8]  = '{3'b000, 3'd0, 1'b1, 1'b1};
      vecs[9]  = '{3'b100, 3'd7, 1'b0, 1'b1};
      vecs[10] = '{3'b101, 3'd6, 1'b0, 1'b0};
      vecs[11] = '{3'b111, 3'd5, 1'b0, 1'b0};

      // ---- reset state ----
      do_reset();
      check("rst out_valid", 32'(bus.out_valid), 0);
      check("rst out_bin", 32'(bus.out_bin), 0);
      check("rst out_dir", 32'(bus.out_dir), 0);
      check("rst out_wrap", 32'(bus.out_wrap), 0);
      check("rst out_step_err", 32'(bus.out_step_err), 0);
      check("rst err_count", 32'(bus.err_count), 0);
      check("rst in_ready", 32'(bus.in_ready), 1);

      // ---- walks ----
      for (int i = 0; i < 12; i++) begin
         bus.in_valid = 1'b1;
         bus.in_gray  = vecs[i].gray;
         step();
         check($sformatf("walk[%0d] valid", i), 32'(bus.out_valid), 1);
         check($sformatf("walk[%0d] bin", i), 32'(bus.out_bin), 32'(vecs[i].bin));
         check($sformatf("walk[%0d] dir", i), 32'(bus.out_dir), 32'(vecs[i].dir));
         check($sformatf("walk[%0d] wrap", i), 32'(bus.out_wrap), 32'(vecs[i].wrap));
         check($sformatf("walk[%0d] step_err", i), 32'(bus.out_step_err), 0);
      end
      check("walk err_count", 32'(bus.err_count), 0);
      bus.in_valid = 1'b0;
      step();
      check("drain out_valid", 32'(bus.out_valid), 0);

      // ---- step errors: 000, 011, 011 ----
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_gray  = 3'b000;
      step();
      check("err w0 step_err", 32'(bus.out_step_err), 0);
      bus.in_gray = 3'b011;
      step();
      check("err w1 bin", 32'(bus.out_bin), 2);
      check("err w1 dir", 32'(bus.out_dir), 0);
      check("err w1 wrap", 32'(bus.out_wrap), 0);
      check("err w1 step_err", 32'(bus.out_step_err), 32'(CHK));
      step();
      check("err w2 step_err", 32'(bus.out_step_err), 32'(CHK));
      check("err w2 bin", 32'(bus.out_bin), 2);
      exp_cnt = CHK ? 8'd2 : 8'd0;
      check("err_count after 2", 32'(bus.err_count), 32'(exp_cnt));
      for (int i = 0; i < 300; i++) step();
      exp_cnt = CHK ? 8'd255 : 8'd0;
      check("err_count saturated", 32'(bus.err_count), 32'(exp_cnt));
      bus.in_valid = 1'b0;

      // ---- backpressure ----
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_gray  = 3'b001;
      step();
      check("bp first bin", 32'(bus.out_bin), 1);
      check("bp first dir", 32'(bus.out_dir), 0);
      bus.out_ready = 1'b0;
      bus.in_gray   = 3'b011;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp[%0d] in_ready", i), 32'(bus.in_ready), 0);
         step();
         check($sformatf("bp[%0d] out_valid", i), 32'(bus.out_valid), 1);
         check($sformatf("bp[%0d] out_bin", i), 32'(bus.out_bin), 1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp release in_ready", 32'(bus.in_ready), 1);
      step();
      check("bp next bin", 32'(bus.out_bin), 2);
      check("bp next valid", 32'(bus.out_valid), 1);
      check("bp next dir", 32'(bus.out_dir), 1);
      bus.in_valid = 1'b0;
      step();
      check("bp drained", 32'(bus.out_valid), 0);

      // ---- reset mid-stream ----
      bus.in_valid = 1'b1;
      bus.in_gray  = 3'b110;
      step();
      check("mid pre valid", 32'(bus.out_valid), 1);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid rst valid", 32'(bus.out_valid), 0);
      check("mid rst bin", 32'(bus.out_bin), 0);
      check("mid rst dir", 32'(bus.out_dir), 0);
      check("mid rst in_ready", 32'(bus.in_ready), 1);
      step();
      rst_n = 1'b1;
      #1;
      bus.in_valid = 1'b1;
      bus.in_gray  = 3'b010;
      step();
      check("post rst bin", 32'(bus.out_bin), 3);
      check("post rst dir", 32'(bus.out_dir), 0);
      check("post rst wrap", 32'(bus.out_wrap), 0);
      check("post rst step_err", 32'(bus.out_step_err), 0);
      check("post rst err_count", 32'(bus.err_count), 0);
      bus.in_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/gray_to_binary_decoder.md
# gray_to_binary_decoder

Registered gray-to-binary decoder with a valid/ready stream on both sides, the inverse of the team's binary-to-gray encoder. It accepts one gray-coded word per handshake, emits its binary value one cycle later, and tracks stepping between consecutive words. Outputs are wrap, count direction and, optionally, single-bit-step violations. It sits on the receive side of gray-coded pointer and counter paths, for example after FIFO pointer transfer or at rotary/position encoder inputs.

## Interface
- WIDTH, 3, bit width of gray input and binary output (≥2)
- ERR_CNT_W, 8, width of saturating step-error counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_gray holds a word
- in_ready  output  1  decoder can accept this cycle
- in_gray  input  WIDTH  gray-coded word
- out_valid  output  1  out_bin holds a decoded word
- out_ready  input  1  downstream accepts this cycle
- out_bin  output  WIDTH  binary value of the accepted gray word
- out_dir  output  1  1 = step up (+1 mod 2^WIDTH), 0 = otherwise
- out_wrap  output  1  step crossed the boundary (max→0 going up, 0→max going down)
- out_step_err  output  1  current word differs from previous accepted word in ≠1 bit
- err_count  output  ERR_CNT_W  saturating count of step errors since reset

## Operation
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] for i = WIDTH-2 down to 0. The decode is purely combinational on in_gray and is registered on accept.
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready. This is a single output register with no bubble on continuous flow.
- On accept:
  - out_bin ← decode(in_gray).
  - out_valid ← 1.
  - The previous-gray and previous-binary history registers update.
- If out_ready is high and no accept happens, out_valid ← 0.
- History state: a has_prev flag. It is cleared by reset and set by the first accept.
  - First word after reset: out_dir = 0, out_wrap = 0, out_step_err = 0.
  - For later words, define prev = previous accepted binary and cur = the new binary:
    - out_dir = (cur == prev+1 mod 2^WIDTH).
    - out_wrap = (out_dir && prev == 2^WIDTH-1) || (!out_dir && cur == 2^WIDTH-1 && prev == 0).
    - Any step that is not ±1 gives out_dir = 0 and out_wrap = 0.
- Repeated identical word (0-bit change): this is a step error when checking is enabled. out_dir = 0, out_wrap = 0.
- Step check: popcount(in_gray ^ prev_gray) ≠ 1 sets out_step_err for that output word. err_count increments by 1 on each such accept and saturates at 2^ERR_CNT_W-1.
- While out_valid && !out_ready, the following hold stable: out_bin, out_dir, out_wrap and out_step_err.

## Timing
- Reset (async assert, sync release), with values:
  - out_valid = 0
  - out_bin = 0
  - out_dir = 0
  - out_wrap = 0
  - out_step_err = 0
  - err_count = 0
  - has_prev = 0
  - in_ready = 1
- Latency: word accepted at edge N is presented on out_* after edge N. It is visible in cycle N+1.
- Throughput: 1 word/cycle while out_ready is held high.
- Simultaneous output drain and new accept in the same cycle: the new word replaces the old one and out_valid stays 1.
- Reset mid-stream: the in-flight word is discarded and history is lost. The next accepted word is treated as the first word.
- err_count updates on the same edge as out_step_err is registered.

## Configuration
- GRAY_STEP_CHECK_EN defined: the popcount checker, out_step_err and err_count logic are compiled in.
- Not defined:
  - out_step_err is tied to 0.
  - err_count is tied to 0.
  - The prev_gray register is removed.
  - Decode, handshake, out_dir and out_wrap are unchanged.

## Test plan
- Upward walk, WIDTH=3, out_ready=1: gray 000,001,011,010,110,111,101,100,000 → out_bin 0..7 then 0. out_dir=1 from the second word onward. out_wrap=1 only on the final 0. out_step_err never set.
- Downward walk: gray 000,100,101,111 → out_bin 0,7,6,5. out_dir=0 throughout. out_wrap=1 on the 7. err_count=0.
- Step errors (with GRAY_STEP_CHECK_EN): gray 000,011,011 → out_step_err 0,1,1 and err_count=2. Drive 300 errored words → err_count holds at 255.
- Backpressure: out_ready=0 for 3 cycles after word 001 is accepted.
  - in_ready=0 during those cycles.
  - out_bin holds 1.
  - Raising out_ready with in_valid=1 and gray 011 gives out_bin=2 on the next cycle with no bubble.
- Reset mid-stream: assert rst_n=0 asynchronously while out_valid=1.
  - All outputs clear immediately.
  - After release, first word 010 → out_bin=3, out_step_err=0, out_dir=0.
- Macro off: the repeated-word sequence gives out_step_err=0 and err_count=0. out_bin is still correct.
